ahb_sram_ctrl: RTL and testbench
================================

# ahb_sram_ctrl

Parametrised AHB-lite slave wrapping an internal synchronous-write, registered-address simple-dual-port SRAM of `2**MEM_AW` 32-bit words. It is the successor to the fixed 1024x32 SRAM slave. It adds:
- byte/halfword writes from HSIZE and HADDR[1:0],
- zero-wait-state back-to-back access with read-after-write forwarding,
- an optional two-cycle ERROR response for illegal transfers.

It sits on the AHB-lite matrix as a memory-mapped RAM slave.

## Interface
- MEM_AW, 10, word-address width; depth = 2**MEM_AW words (legal 4..16)
- I_HCLK  in  1  bus clock; all state on rising edge
- I_HRESETn  in  1  asynchronous active-low reset
- I_HSEL  in  1  slave select
- I_HADDR  in  32  byte address; word index = I_HADDR[MEM_AW+1:2], upper bits ignored (aliasing)
- I_HTRANS  in  2  transfer type; I_HTRANS[1]=1 means NONSEQ/SEQ
- I_HWRITE  in  1  1=write
- I_HSIZE  in  3  000 byte, 001 halfword, 010 word, others illegal
- I_HBURST, I_HPROT, I_HMASTLOCK  in  3/4/1  accepted, ignored
- I_HWDATA  in  32  write data, data phase
- I_HREADY  in  1  bus ready
- O_HRDATA  out  32  read data, data phase
- O_HREADYOUT  out  1  slave ready
- O_HRESP  out  1  0=OKAY, 1=ERROR

## Operation
**Transfer acceptance**
- Accept = I_HSEL & I_HREADY & I_HTRANS[1]; this is sampled only in the address phase.
- Legal transfers:
  - byte at any alignment;
  - halfword with I_HADDR[0]=0;
  - word with I_HADDR[1:0]=0.

**Byte enables (be)**
- byte: 4'b0001 << HADDR[1:0]
- halfword: HADDR[1] ? 4'b1100 : 4'b0011
- word: 4'b1111

**Data-phase registers**
- On a legal accept, register: dp_valid, dp_write, dp_addr (word index), dp_be.
- A non-accepted cycle with I_HREADY=1 clears dp_valid.

**Reads**
- The memory read address is I_HADDR word index in the address phase.
- The memory read port registers the address; q is valid in the data phase.
- O_HRDATA = full 32-bit word during a read data phase, otherwise 32'h0.

**Writes**
- At the end of the write data phase (I_HREADY=1), memory bytes with dp_be[i]=1 take I_HWDATA[8i+7:8i]. Other bytes are unchanged.

**Read-after-write forwarding**
- Condition: a read is accepted in the same cycle as a write data phase to the same word index.
- In that case, register fwd=1, fwd_be and fwd_data.
- In the following read data phase, bytes with fwd_be=1 come from fwd_data; the rest come from the memory.

**State machine**
- ST_OK: O_HREADYOUT=1, O_HRESP=0. An illegal accept moves to ST_ERR1.
- ST_ERR1: O_HREADYOUT=0, O_HRESP=1. Unconditionally moves to ST_ERR2.
- ST_ERR2: O_HREADYOUT=1, O_HRESP=1. Next state is ST_OK.
  - A new accept in ST_ERR2 is processed exactly as from ST_OK, including entering ST_ERR1 again if it is illegal.
- Illegal transfers never write memory, and their reads return 32'h0.
- IDLE/BUSY transfers and unselected cycles get an OKAY response with no memory effect.

## Timing
**Reset values**
- O_HREADYOUT=1, O_HRESP=0, O_HRDATA=0
- dp_valid=0, fwd=0, state ST_OK
- Memory contents are not reset.

**Latency**
- Reads and writes are zero-wait-state: one address phase plus one data phase. Back-to-back transfers are sustained at one per cycle.

**Stalls and resets**
- A stall by another slave (I_HREADY=0) holds all data-phase registers and the memory read address. The held address is the registered dp_addr.
- Reset asserted mid-write data phase: the write may be lost, and all outputs return to their reset values asynchronously.

**Address handling**
- Word indices ≥ depth alias modulo depth. The address wraps at 2**MEM_AW-1 → 0.

## Configuration
- SRAM_AHB_ERR_EN defined: illegal transfers handled as above, with the two-cycle ERROR response.
- SRAM_AHB_ERR_EN undefined:
  - the FSM is removed; O_HREADYOUT=1 and O_HRESP=0 are constant;
  - illegal sizes are forced to a word access at the aligned address HADDR[MEM_AW+1:2] with be=4'b1111;
  - misaligned halfwords use be derived from HADDR[1].

## Test plan
- Reset: assert I_HRESETn=0 mid-transfer → O_HREADYOUT=1, O_HRESP=0, O_HRDATA=0 immediately.
- Word write 0xDEADBEEF to 0x010, then byte write 0xAA to 0x011, then word read 0x010 → 0xDEADAABEF... is ambiguous, so: required result is 0xDEADAAEF, OKAY, zero waits.
- Back-to-back: halfword write 0x1234 to 0x022 immediately followed by word read 0x020 (memory previously 0x0) → forwarded 0x12340000 in the next cycle.
- Aliasing with MEM_AW=4: write 0x55 word to 0x040, read 0x000 → 0x00000055.
- With SRAM_AHB_ERR_EN: word write to 0x003 → HREADYOUT 0 / HRESP 1, then HREADYOUT 1 / HRESP 1; memory unchanged. A following legal read gets OKAY.
- Stall: I_HREADY held 0 for 3 cycles during a read data phase → O_HRDATA stable and correct throughout; no memory write.

Source files
------------

// File: rtl/ahb_sram_ctrl.sv
// AHB-lite slave around a 2**MEM_AW x 32 simple-dual-port SRAM with byte lanes and RAW forwarding.
// Define SRAM_AHB_ERR_EN to get the two-cycle ERROR response for illegal transfers.
module ahb_sram_ctrl #(
  parameter int MEM_AW = 10
) (
  input  logic        I_HCLK,
  input  logic        I_HRESETn,
  input  logic        I_HSEL,
  input  logic [31:0] I_HADDR,
  input  logic [1:0]  I_HTRANS,
  input  logic        I_HWRITE,
  input  logic [2:0]  I_HSIZE,
  input  logic [2:0]  I_HBURST,
  input  logic [3:0]  I_HPROT,
  input  logic        I_HMASTLOCK,
  input  logic [31:0] I_HWDATA,
  input  logic        I_HREADY,
  output logic [31:0] O_HRDATA,
  output logic        O_HREADYOUT,
  output logic        O_HRESP
);
  localparam int DEPTH = 2**MEM_AW;

  logic              accept, acc_ok, a_legal;
  logic [MEM_AW-1:0] a_idx;
  logic [3:0]        a_be;

  assign accept = I_HSEL & I_HREADY & I_HTRANS[1];
  assign a_idx  = I_HADDR[MEM_AW+1:2];

  always_comb begin
    a_be = 4'b1111;
    case (I_HSIZE)
      3'b000:  a_be = 4'b0001 << I_HADDR[1:0];
      3'b001:  a_be = I_HADDR[1] ? 4'b1100 : 4'b0011;
      default: a_be = 4'b1111;
    endcase
  end

`ifdef SRAM_AHB_ERR_EN
  always_comb begin
    a_legal = 1'b0;
    case (I_HSIZE)
      3'b000:  a_legal = 1'b1;
      3'b001:  a_legal = ~I_HADDR[0];
      3'b010:  a_legal = (I_HADDR[1:0] == 2'b00);
      default: a_legal = 1'b0;
    endcase
  end
`else
  // Without the error path every transfer is serviced; odd sizes become word accesses.
  assign a_legal = 1'b1;
`endif

  assign acc_ok = accept & a_legal;

  // Data-phase registers
  logic              dp_valid_q, dp_valid_d, dp_write_q, dp_write_d;
  logic [MEM_AW-1:0] dp_addr_q, dp_addr_d;
  logic [3:0]        dp_be_q, dp_be_d;

  always_comb begin
    dp_valid_d = dp_valid_q;
    dp_write_d = dp_write_q;
    dp_addr_d  = dp_addr_q;
    dp_be_d    = dp_be_q;
    if (I_HREADY) begin
      dp_valid_d = acc_ok;
      if (acc_ok) begin
        dp_write_d = I_HWRITE;
        dp_addr_d  = a_idx;
        dp_be_d    = a_be;
      end
    end
  end

  always_ff @(posedge I_HCLK or negedge I_HRESETn) begin
    if (!I_HRESETn) begin
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_addr_q  <= '0;
      dp_be_q    <= '0;
    end else begin
      dp_valid_q <= dp_valid_d;
      dp_write_q <= dp_write_d;
      dp_addr_q  <= dp_addr_d;
      dp_be_q    <= dp_be_d;
    end
  end

  logic wr_en, fwd_hit;
  assign wr_en   = dp_valid_q & dp_write_q & I_HREADY;
  // The SRAM returns the pre-write word when read and write hit the same edge.
  assign fwd_hit = acc_ok & ~I_HWRITE & wr_en & (a_idx == dp_addr_q);

  logic        fwd_q, fwd_d;
  logic [3:0]  fwd_be_q, fwd_be_d;
  logic [31:0] fwd_data_q, fwd_data_d;

  always_comb begin
    fwd_d      = fwd_q;
    fwd_be_d   = fwd_be_q;
    fwd_data_d = fwd_data_q;
    if (I_HREADY) begin
      fwd_d = fwd_hit;
      if (fwd_hit) begin
        fwd_be_d   = dp_be_q;
        fwd_data_d = I_HWDATA;
      end
    end
  end

  always_ff @(posedge I_HCLK or negedge I_HRESETn) begin
    if (!I_HRESETn) begin
      fwd_q      <= 1'b0;
      fwd_be_q   <= '0;
      fwd_data_q <= '0;
    end else begin
      fwd_q      <= fwd_d;
      fwd_be_q   <= fwd_be_d;
      fwd_data_q <= fwd_data_d;
    end
  end

  // A stalled data phase keeps re-reading its own word so the output stays valid.
  logic [MEM_AW-1:0] mem_raddr;
  logic [3:0][7:0]   rd_merged;
  assign mem_raddr = I_HREADY ? a_idx : dp_addr_q;

  for (genvar b = 0; b < 4; b++) begin : g_lane
    logic [7:0] ram [DEPTH];
    logic [7:0] rd_q;
    always_ff @(posedge I_HCLK) begin
      rd_q <= ram[mem_raddr];
      if (wr_en && dp_be_q[b]) ram[dp_addr_q] <= I_HWDATA[8*b +: 8];
    end
    assign rd_merged[b] = (fwd_q && fwd_be_q[b]) ? fwd_data_q[8*b +: 8] : rd_q;
  end

  assign O_HRDATA = (dp_valid_q && !dp_write_q) ? rd_merged : 32'h0;

`ifdef SRAM_AHB_ERR_EN
  localparam logic [1:0] ST_OK   = 2'd0;
  localparam logic [1:0] ST_ERR1 = 2'd1;
  localparam logic [1:0] ST_ERR2 = 2'd2;

  logic [1:0] state_q, state_d;

  always_comb begin
    state_d = ST_OK;
    case (state_q)
      ST_ERR1: state_d = ST_ERR2;
      default: if (accept && !a_legal) state_d = ST_ERR1;
    endcase
  end

  always_ff @(posedge I_HCLK or negedge I_HRESETn) begin
    if (!I_HRESETn) state_q <= ST_OK;
    else            state_q <= state_d;
  end

  assign O_HREADYOUT = (state_q != ST_ERR1);
  assign O_HRESP     = (state_q != ST_OK);
`else
  assign O_HREADYOUT = 1'b1;
  assign O_HRESP     = 1'b0;
`endif

  logic unused_ok;
  assign unused_ok = ^{I_HBURST, I_HPROT, I_HMASTLOCK, I_HTRANS[0], I_HADDR[31:MEM_AW+2]};

endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// Bench for ahb_sram_ctrl (MEM_AW=4): directed scenarios then random traffic vs. a word-array model.
module tb_ahb_sram_ctrl;
  localparam int AW = 4;

  logic        I_HCLK = 1'b0;
  logic        I_HRESETn = 1'b1;
  logic        I_HSEL = 1'b0;
  logic [31:0] I_HADDR = '0;
  logic [1:0]  I_HTRANS = '0;
  logic        I_HWRITE = 1'b0;
  logic [2:0]  I_HSIZE = 3'd2;
  logic [2:0]  I_HBURST = '0;
  logic [3:0]  I_HPROT = '0;
  logic        I_HMASTLOCK = 1'b0;
  logic [31:0] I_HWDATA = '0;
  logic        I_HREADY;
  logic [31:0] O_HRDATA;
  logic        O_HREADYOUT, O_HRESP;
  logic        stall = 1'b0;

  assign I_HREADY = O_HREADYOUT & ~stall;
  always #5 I_HCLK = ~I_HCLK;

  ahb_sram_ctrl #(.MEM_AW(AW)) dut (
    .I_HCLK(I_HCLK), .I_HRESETn(I_HRESETn), .I_HSEL(I_HSEL), .I_HADDR(I_HADDR),
    .I_HTRANS(I_HTRANS), .I_HWRITE(I_HWRITE), .I_HSIZE(I_HSIZE), .I_HBURST(I_HBURST),
    .I_HPROT(I_HPROT), .I_HMASTLOCK(I_HMASTLOCK), .I_HWDATA(I_HWDATA), .I_HREADY(I_HREADY),
    .O_HRDATA(O_HRDATA), .O_HREADYOUT(O_HREADYOUT), .O_HRESP(O_HRESP)
  );

  int checks = 0;
  int errors = 0;

  // Reference: plain word array; reads simply see the latest completed writes.
  logic [31:0] mm [16];
  typedef struct packed {logic v; logic w; logic [3:0] idx; logic [3:0] be;} pend_t;
  pend_t pend;
  int    phase;  // 0 OKAY, 1 first ERROR cycle, 2 second ERROR cycle

  function automatic logic [3:0] ref_be(input logic [2:0] sz, input logic [31:0] a);
    logic [3:0] one;
    one = 4'b0001;
    if (sz == 3'd0) return one << a[1:0];
    if (sz == 3'd1) return a[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic ref_legal(input logic [2:0] sz, input logic [31:0] a);
`ifdef SRAM_AHB_ERR_EN
    return (sz == 3'd0) || (sz == 3'd1 && !a[0]) || (sz == 3'd2 && a[1:0] == 2'b00);
`else
    return 1'b1;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one address phase (plus HWDATA for the current data phase), clock, then check.
  task automatic step(input logic sel, input logic [1:0] tr, input logic wr,
                      input logic [31:0] addr, input logic [2:0] sz,
                      input logic [31:0] wd, input logic stl);
    logic hr, acc, lg;
    I_HSEL = sel; I_HTRANS = tr; I_HWRITE = wr; I_HADDR = addr; I_HSIZE = sz;
    I_HWDATA = wd; stall = stl;
    I_HBURST = 3'($urandom); I_HPROT = 4'($urandom); I_HMASTLOCK = 1'($urandom);
    hr  = O_HREADYOUT & ~stl;
    acc = sel & tr[1] & hr;
    lg  = ref_legal(sz, addr);
    @(posedge I_HCLK); #1;
    if (hr) begin
      if (pend.v && pend.w)
        for (int b = 0; b < 4; b++) if (pend.be[b]) mm[pend.idx][8*b +: 8] = wd[8*b +: 8];
      pend.v   = acc && lg;
      pend.w   = wr;
      pend.idx = addr[AW+1:2];
      pend.be  = ref_be(sz, addr);
    end
    if (phase == 1) phase = 2;
    else if (acc && !lg) phase = 1;
    else phase = 0;
    chk("hrdata", O_HRDATA, (pend.v && !pend.w) ? mm[pend.idx] : 32'h0);
    chk("hreadyout", {31'h0, O_HREADYOUT}, {31'h0, phase != 1});
    chk("hresp", {31'h0, O_HRESP}, {31'h0, phase != 0});
  endtask

  task automatic idle(input logic [31:0] wd);
    step(1'b0, 2'b00, 1'b0, 32'h0, 3'd2, wd, 1'b0);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] wd);
    step(1'b1, 2'b10, 1'b0, a, 3'd2, wd, 1'b0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
    step(1'b1, 2'b10, 1'b1, a, sz, wd, 1'b0);
  endtask

  initial begin
    pend = '0;
    phase = 0;
    #2 I_HRESETn = 1'b0;
    #1;
    chk("rst_hrdata", O_HRDATA, 32'h0);
    chk("rst_hreadyout", {31'h0, O_HREADYOUT}, 32'h1);
    chk("rst_hresp", {31'h0, O_HRESP}, 32'h0);
    @(posedge I_HCLK); #1 I_HRESETn = 1'b1;

    for (int i = 0; i < 16; i++) wr(32'(i * 4), 3'd2, 32'h0);
    idle(32'h0);

    // Word write, byte overwrite, then a forwarded read and a plain read.
    wr(32'h010, 3'd2, 32'h0);
    wr(32'h011, 3'd0, 32'hDEADBEEF);
    rd(32'h010, 32'h0000AA00);
    chk("byte_merge_fwd", O_HRDATA, 32'hDEADAAEF);
    idle(32'h0);
    rd(32'h010, 32'h0);
    chk("byte_merge_mem", O_HRDATA, 32'hDEADAAEF);
    idle(32'h0);

    // Halfword write directly followed by a read of the same word.
    wr(32'h022, 3'd1, 32'h0);
    rd(32'h020, 32'h12340000);
    chk("fwd_half", O_HRDATA, 32'h12340000);
    idle(32'h0);

    // 0x040 aliases word 0 when depth is 16.
    wr(32'h040, 3'd2, 32'h0);
    idle(32'h00000055);
    rd(32'h000, 32'h0);
    chk("alias", O_HRDATA, 32'h00000055);
    idle(32'h0);

    // Stall during a read data phase, with a competing address on the bus.
    rd(32'h010, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 2'b10, 1'b1, 32'h030, 3'd2, $urandom, 1'b1);
      chk("stall_hold", O_HRDATA, 32'hDEADAAEF);
    end
    idle(32'h0);
    rd(32'h030, 32'h0);
    chk("stall_no_write", O_HRDATA, 32'h0);
    idle(32'h0);

    // Asynchronous reset in the middle of a read data phase.
    rd(32'h010, 32'h0);
    I_HRESETn = 1'b0;
    I_HSEL = 1'b0; I_HTRANS = 2'b00;
    #1;
    chk("midrst_hrdata", O_HRDATA, 32'h0);
    chk("midrst_hreadyout", {31'h0, O_HREADYOUT}, 32'h1);
    chk("midrst_hresp", {31'h0, O_HRESP}, 32'h0);
    pend = '0;
    phase = 0;
    @(posedge I_HCLK); #1 I_HRESETn = 1'b1;
    rd(32'h010, 32'h0);
    chk("mem_kept", O_HRDATA, 32'hDEADAAEF);
    idle(32'h0);

`ifdef SRAM_AHB_ERR_EN
    wr(32'h003, 3'd2, 32'h0);
    chk("err1_ready", {31'h0, O_HREADYOUT}, 32'h0);
    chk("err1_resp", {31'h0, O_HRESP}, 32'h1);
    idle(32'hFFFFFFFF);
    chk("err2_ready", {31'h0, O_HREADYOUT}, 32'h1);
    chk("err2_resp", {31'h0, O_HRESP}, 32'h1);
    rd(32'h000, 32'h0);
    chk("err_mem_unchanged", O_HRDATA, 32'h00000055);
    chk("err_then_okay", {31'h0, O_HRESP}, 32'h0);
    wr(32'h021, 3'd1, 32'h0);
    idle(32'hFFFFFFFF);
    step(1'b1, 2'b10, 1'b0, 32'h000, 3'd3, 32'h0, 1'b0);
    chk("err2_reenter", {31'h0, O_HREADYOUT}, 32'h0);
    idle(32'h0);
    idle(32'h0);
`endif

    for (int n = 0; n < 1500; n++) begin
      logic [2:0] sz;
      sz = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      step($urandom_range(0, 7) != 0, 2'($urandom), 1'($urandom), 32'($urandom_range(0, 255)),
           sz, $urandom, $urandom_range(0, 7) == 0);
    end
    idle(32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
